// File: rtl/mem_sig_monitor.sv
// rtl/mem_sig_monitor.sv - memory-bus signature monitor: stop/trap/simlen FSM plus register-dump FIFO
// Optional MEM_SIG_MONITOR_STRB_CHECK_EN: a hit additionally requires all byte strobes set.
module mem_sig_monitor #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int NUM_CH = 2,
  parameter logic [ADDR_W-1:0] STOP_ADDR = '0,
  parameter logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'(8),
  parameter logic [ADDR_W-1:0] DUMP_BASE = ADDR_W'(16),
  parameter int DRAIN_CYCLES = 50,
  parameter int CNT_W = 32,
  parameter int IDX_W = 6,
  parameter int CH0_IDX_INIT = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_strb_i,
  input  logic [CNT_W-1:0]  simlen_i,
  input  logic              stop_on_trap_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [CH_W-1:0]   dump_ch_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [1:0]        done_cause_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              trap_seen_o,
  output logic [7:0]        drop_cnt_o
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2} state_e;
  localparam logic [1:0] C_NONE = 2'd0, C_STOP = 2'd1, C_TRAP = 2'd2, C_SIMLEN = 2'd3;
  localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int E_W = CH_W + IDX_W + DATA_W;

  state_e              state_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic [1:0]          cause_q;
  logic [CNT_W-1:0]    cycle_cnt_q;
  logic                trap_seen_q;
  logic [1:0]          fcnt_q;
  logic [E_W-1:0]      slot_q [2];
  logic [7:0]          drop_q;
  logic [IDX_W-1:0]    idx_q [2**CH_W];

  logic wr_ok;
`ifdef MEM_SIG_MONITOR_STRB_CHECK_EN
  assign wr_ok = mem_req_i & mem_we_i & (&mem_strb_i);
`else
  assign wr_ok = mem_req_i & mem_we_i;
  logic unused_strb;
  assign unused_strb = ^mem_strb_i;
`endif

  logic run, stop_hit, trap_hit, simlen_hit;
  assign run        = (state_q == S_RUN);
  assign stop_hit   = wr_ok & (mem_addr_i == STOP_ADDR);
  assign trap_hit   = wr_ok & (mem_addr_i == TRAP_ADDR);
  assign simlen_hit = (simlen_i != '0) & (cycle_cnt_q == simlen_i - CNT_W'(1));

  logic            dump_hit;
  logic [CH_W-1:0] dump_ch;
  always_comb begin
    dump_hit = 1'b0;
    dump_ch  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ok && (mem_addr_i == DUMP_BASE + ADDR_W'(8 * c))) begin
        dump_hit = 1'b1;
        dump_ch  = CH_W'(c);
      end
    end
  end

  logic           push, pop;
  logic [E_W-1:0] push_entry;
  assign push       = run & dump_hit;
  assign pop        = (fcnt_q != 2'd0) & dump_ready_i;
  assign push_entry = {dump_ch, idx_q[dump_ch], mem_wdata_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_RUN;
      drain_q     <= '0;
      cause_q     <= C_NONE;
      cycle_cnt_q <= '0;
      trap_seen_q <= 1'b0;
    end else begin
      trap_seen_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          trap_seen_q <= trap_hit & ~stop_on_trap_i;
          if (stop_hit || (trap_hit && stop_on_trap_i)) begin
            cause_q <= stop_hit ? C_STOP : C_TRAP;
            if (DRAIN_CYCLES == 0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_DRAIN;
              drain_q <= DRAIN_W'(DRAIN_CYCLES);
            end
          end else if (simlen_hit) begin
            state_q <= S_DONE;
            cause_q <= C_SIMLEN;
          end else begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_W'(1)) begin
            state_q <= S_DONE;
            drain_q <= '0;
          end else begin
            drain_q <= drain_q - DRAIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Two-slot shift FIFO: slot 0 is always the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt_q    <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      drop_q    <= 8'd0;
      for (int c = 0; c < 2**CH_W; c++) idx_q[c] <= (c == 0) ? IDX_W'(CH0_IDX_INIT) : '0;
    end else begin
      if (push) idx_q[dump_ch] <= idx_q[dump_ch] + IDX_W'(1);
      case ({push, pop})
        2'b10: begin
          if (fcnt_q == 2'd2) begin
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
          end else begin
            slot_q[fcnt_q[0]] <= push_entry;
            fcnt_q            <= fcnt_q + 2'd1;
          end
        end
        2'b01: begin
          slot_q[0] <= slot_q[1];
          fcnt_q    <= fcnt_q - 2'd1;
        end
        2'b11: begin
          if (fcnt_q == 2'd2) begin
            slot_q[0] <= slot_q[1];
            slot_q[1] <= push_entry;
          end else begin
            slot_q[0] <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign dump_valid_o = (fcnt_q != 2'd0);
  assign {dump_ch_o, dump_idx_o, dump_data_o} = dump_valid_o ? slot_q[0] : '0;
  assign state_o      = state_q;
  assign done_o       = (state_q == S_DONE);
  assign done_cause_o = cause_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign trap_seen_o  = trap_seen_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_mem_sig_monitor.sv
// tb/tb_mem_sig_monitor.sv - self-checking bench for mem_sig_monitor
// Queue-based reference model compared every cycle, plus literal expectations.
module tb_mem_sig_monitor;
  localparam int NCH = 2;
  localparam int DRN = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0, we = 1'b0, sot = 1'b0, ready = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0]  strb = 8'hFF;
  logic [31:0] simlen = '0;
  logic        dump_valid, done, trap_seen;
  logic [0:0]  dump_ch;
  logic [5:0]  dump_idx;
  logic [63:0] dump_data;
  logic [1:0]  state, cause;
  logic [31:0] cycle_cnt;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  mem_sig_monitor dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_i(req), .mem_we_i(we), .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_strb_i(strb),
    .simlen_i(simlen), .stop_on_trap_i(sot),
    .dump_valid_o(dump_valid), .dump_ready_i(ready), .dump_ch_o(dump_ch),
    .dump_idx_o(dump_idx), .dump_data_o(dump_data),
    .state_o(state), .done_o(done), .done_cause_o(cause),
    .cycle_cnt_o(cycle_cnt), .trap_seen_o(trap_seen), .drop_cnt_o(drop_cnt)
  );

  typedef struct { int ch; int idx; logic [63:0] data; } rec_t;

  int          errors = 0, checks = 0;
  int          m_state, m_cause, m_drain, m_drop;
  logic [31:0] m_cnt;
  int          m_idx [NCH];
  bit          m_trap;
  rec_t        m_q [$];
  rec_t        got [$];

  task automatic chk(input string n, input longint unsigned a, input longint unsigned e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_cause = 0; m_drain = 0; m_drop = 0; m_cnt = '0; m_trap = 0;
    m_q.delete();
    for (int c = 0; c < NCH; c++) m_idx[c] = (c == 0) ? 1 : 0;
  endfunction

  function automatic bit is_hit(input logic [63:0] a);
`ifdef MEM_SIG_MONITOR_STRB_CHECK_EN
    return req && we && (addr == a) && (strb == 8'hFF);
`else
    return req && we && (addr == a);
`endif
  endfunction

  function automatic void enter_stop(input int c);
    m_cause = c;
    if (DRN == 0) m_state = 2;
    else begin m_state = 1; m_drain = DRN; end
  endfunction

  function automatic void model_step();
    rec_t r;
    bit   nt;
    if (!rst_n) begin model_reset(); return; end
    nt = 0;
    if (m_q.size() > 0 && ready) void'(m_q.pop_front());
    if (m_state == 0) begin
      for (int c = 0; c < NCH; c++) begin
        if (is_hit(64'(16 + 8 * c))) begin
          r.ch = c; r.idx = m_idx[c]; r.data = wdata;
          if (m_q.size() < 2) m_q.push_back(r);
          else if (m_drop < 255) m_drop++;
          m_idx[c] = (m_idx[c] + 1) % 64;
        end
      end
      nt = is_hit(64'd8) && !sot;
      if (is_hit(64'd0)) enter_stop(1);
      else if (is_hit(64'd8) && sot) enter_stop(2);
      else if (simlen != 0 && m_cnt == simlen - 1) begin m_state = 2; m_cause = 3; end
      else m_cnt++;
    end else if (m_state == 1) begin
      m_drain--;
      if (m_drain == 0) m_state = 2;
    end
    m_trap = nt;
  endfunction

  task automatic check_all();
    chk("state", state, m_state);
    chk("done", done, m_state == 2);
    chk("cause", cause, m_cause);
    chk("cycle_cnt", cycle_cnt, m_cnt);
    chk("trap_seen", trap_seen, m_trap);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("dump_valid", dump_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("dump_ch", dump_ch, m_q[0].ch);
      chk("dump_idx", dump_idx, m_q[0].idx);
      chk("dump_data", dump_data, m_q[0].data);
    end else begin
      chk("dump_ch_empty", dump_ch, 0);
      chk("dump_idx_empty", dump_idx, 0);
      chk("dump_data_empty", dump_data, 0);
    end
  endtask

  task automatic cyc();
    rec_t r;
    if (rst_n && dump_valid && ready) begin
      r.ch = int'(dump_ch); r.idx = int'(dump_idx); r.data = dump_data;
      got.push_back(r);
    end
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc();
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic chk_rec(input int i, input int ch, input int idx, input logic [63:0] d);
    if (got.size() > i) begin
      chk($sformatf("rec%0d_ch", i), got[i].ch, ch);
      chk($sformatf("rec%0d_idx", i), got[i].idx, idx);
      chk($sformatf("rec%0d_data", i), got[i].data, d);
    end else begin
      chk($sformatf("rec%0d_present", i), got.size(), i + 1);
    end
  endtask

  initial begin
    #2;
    do_reset();
    chk("lit_reset_state", state, 0);
    chk("lit_reset_cnt", cycle_cnt, 0);
    chk("lit_reset_valid", dump_valid, 0);

    // Stop at cycle 5, drain 50 cycles, then terminal DONE
    idle(5);
    chk("lit_cnt5", cycle_cnt, 5);
    wr(64'd0, 64'd0);
    chk("lit_drain_entry", state, 1);
    idle(DRN - 1);
    chk("lit_drain_last", state, 1);
    idle(1);
    chk("lit_done_state", state, 2);
    chk("lit_done_cause", cause, 1);
    chk("lit_done_cnt", cycle_cnt, 5);
    chk("lit_done_o", done, 1);
    ready = 1'b1;
    wr(64'd16, 64'h55);
    wr(64'd8, 64'd0);
    chk("lit_done_ignores_dump", dump_valid, 0);
    chk("lit_done_terminal", state, 2);

    // Reset abandons DRAIN and clears the FIFO
    ready = 1'b0;
    do_reset();
    wr(64'd16, 64'h11);
    wr(64'd0, 64'd0);
    idle(3);
    do_reset();
    chk("lit_rst_drain_state", state, 0);
    chk("lit_rst_drain_done", done, 0);
    chk("lit_rst_drain_valid", dump_valid, 0);

    // Trap without and with stop_on_trap
    sot = 1'b0;
    wr(64'd8, 64'd0);
    chk("lit_trap_pulse", trap_seen, 1);
    chk("lit_trap_run", state, 0);
    idle(1);
    chk("lit_trap_pulse_end", trap_seen, 0);
    sot = 1'b1;
    wr(64'd8, 64'd0);
    chk("lit_trap_drain", state, 1);
    idle(DRN);
    chk("lit_trap_cause", cause, 2);
    sot = 1'b0;

    // simlen expiry, then stop racing with expiry
    simlen = 32'd100;
    do_reset();
    idle(99);
    chk("lit_simlen_run", state, 0);
    idle(1);
    chk("lit_simlen_done", state, 2);
    chk("lit_simlen_cause", cause, 3);
    chk("lit_simlen_cnt", cycle_cnt, 99);
    do_reset();
    idle(99);
    wr(64'd0, 64'd0);
    chk("lit_race_cause", cause, 1);
    chk("lit_race_state", state, 1);
    simlen = '0;

    // Dump ordering with ready high
    do_reset();
    ready = 1'b1;
    wr(64'd16, 64'hA);
    wr(64'd24, 64'hB);
    wr(64'd16, 64'hC);
    idle(3);
    chk("lit_rec_count", got.size(), 3);
    chk_rec(0, 0, 1, 64'hA);
    chk_rec(1, 1, 0, 64'hB);
    chk_rec(2, 0, 2, 64'hC);

    // Overflow drop, then idx continues past the dropped entry
    do_reset();
    ready = 1'b0;
    wr(64'd16, 64'd1);
    wr(64'd16, 64'd2);
    wr(64'd16, 64'd3);
    chk("lit_drop1", drop_cnt, 1);
    chk("lit_held_valid", dump_valid, 1);
    ready = 1'b1;
    idle(2);
    wr(64'd16, 64'd4);
    idle(1);
    chk("lit_drop_recs", got.size(), 3);
    chk_rec(0, 0, 1, 64'd1);
    chk_rec(1, 0, 2, 64'd2);
    chk_rec(2, 0, 4, 64'd4);

    // Push into a full FIFO while popping is accepted
    do_reset();
    ready = 1'b0;
    wr(64'd24, 64'h21);
    wr(64'd24, 64'h22);
    ready = 1'b1;
    wr(64'd24, 64'h23);
    chk("lit_pushpop_nodrop", drop_cnt, 0);
    idle(3);

    // Index wrap across both channels, plus a non-channel address
    for (int i = 0; i < 70; i++) wr((i % 2 == 0) ? 64'd16 : 64'd24, 64'(i * 3 + 7));
    wr(64'd32, 64'hDEAD);
    idle(3);

    // Drop counter saturation
    ready = 1'b0;
    for (int i = 0; i < 260; i++) wr(64'd16, 64'(i));
    chk("lit_drop_sat", drop_cnt, 255);

    // Partial-strobe stop write
    do_reset();
    strb = 8'h0F;
    wr(64'd0, 64'd0);
`ifdef MEM_SIG_MONITOR_STRB_CHECK_EN
    chk("lit_strb_blocked", state, 0);
`else
    chk("lit_strb_ignored", state, 1);
`endif
    strb = 8'hFF;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
